// File: rtl/vcore_pkg.sv
// vcore_pkg: shared FSM state type, bus width defaults and timeout read data for the dmem arbiter
package vcore_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [15:0] ERR_DATA = 16'hDEAD;
endpackage

// File: rtl/vcore_dmem_arbiter_if.sv
// vcore_dmem_arbiter_if: single-port data memory bus (arbiter is master, memory model is slave)
interface vcore_dmem_arbiter_if #(
  parameter int DATA_W = vcore_pkg::DATA_W,
  parameter int ADDR_W = vcore_pkg::ADDR_W
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic ack;
  modport master(output req, we, addr, wdata, input rdata, ack);
  modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vcore_rr_pick.sv
// vcore_rr_pick: two-way round-robin picker, a tie goes to the core not granted last
module vcore_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx = &req ? ~last_grant : req[1];
endmodule

// File: rtl/vcore_dmem_arbiter.sv
// vcore_dmem_arbiter: round-robin sharing of one single-port data memory between two vcore dmem ports, with ack timeout
module vcore_dmem_arbiter #(
  parameter int DATA_W = vcore_pkg::DATA_W,
  parameter int ADDR_W = vcore_pkg::ADDR_W,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = vcore_pkg::ERR_DATA
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_enable_i,
  input  logic              c0_write_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [DATA_W-1:0] c0_wdata_i,
  output logic [DATA_W-1:0] c0_rdata_o,
  output logic              c0_valid_o,
  input  logic              c1_enable_i,
  input  logic              c1_write_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [DATA_W-1:0] c1_wdata_i,
  output logic [DATA_W-1:0] c1_rdata_o,
  output logic              c1_valid_o,
  vcore_dmem_arbiter_if.master mem,
  output logic              err_o
);
  import vcore_pkg::*;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic winner_q, winner_d;
  logic req_q, req_d;
  logic we_q, we_d;
  logic err_q, err_d;
  logic valid0_q, valid0_d;
  logic valid1_q, valid1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic gnt_valid, gnt_idx, timeout, done;
  logic [DATA_W-1:0] resp_data;
  vcore_rr_pick u_pick (
    .req       ({c1_enable_i, c0_enable_i}),
    .last_grant(last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );
  assign timeout = cnt_q == CNT_W'(TIMEOUT - 1);
  assign done = mem.ack | timeout;
  assign resp_data = mem.ack ? (we_q ? '0 : mem.rdata) : ERR_DATA;
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    winner_d = winner_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        state_d = BUSY;
        winner_d = gnt_idx;
        req_d = 1'b1;
        we_d = gnt_idx ? c1_write_i : c0_write_i;
        addr_d = gnt_idx ? c1_addr_i : c0_addr_i;
        wdata_d = gnt_idx ? c1_wdata_i : c0_wdata_i;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = RESP;
          req_d = 1'b0;
          err_d = err_q | ~mem.ack;
          rdata0_d = winner_q ? rdata0_q : resp_data;
          rdata1_d = winner_q ? resp_data : rdata1_q;
          valid0_d = ~winner_q;
          valid1_d = winner_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_grant_d = winner_q;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      winner_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      winner_q <= winner_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      cnt_q <= cnt_d;
    end
  end
  assign mem.req = req_q;
  assign mem.we = we_q;
  assign mem.addr = addr_q;
  assign mem.wdata = wdata_q;
  assign c0_rdata_o = rdata0_q;
  assign c1_rdata_o = rdata1_q;
  assign c0_valid_o = valid0_q;
  assign c1_valid_o = valid1_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_vcore_dmem_arbiter.sv
// tb_vcore_dmem_arbiter: directed table, corner sequences and randomized model check of the dmem arbiter
module tb_vcore_dmem_arbiter;
  localparam int T = 15;
  typedef struct {
    logic core;
    logic we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int lat;
    logic [15:0] rd;
    logic [15:0] exp_rd;
    logic exp_err;
  } tv_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en[2], wr[2], vo[2];
  logic [15:0] ad[2], wd[2], rdo[2];
  logic err_o;
  int n_chk = 0;
  int n_fail = 0;
  tv_t tv[8];
  vcore_dmem_arbiter_if mem_if ();
  vcore_dmem_arbiter #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .c0_enable_i(en[0]),
    .c0_write_i (wr[0]),
    .c0_addr_i  (ad[0]),
    .c0_wdata_i (wd[0]),
    .c0_rdata_o (rdo[0]),
    .c0_valid_o (vo[0]),
    .c1_enable_i(en[1]),
    .c1_write_i (wr[1]),
    .c1_addr_i  (ad[1]),
    .c1_wdata_i (wd[1]),
    .c1_rdata_o (rdo[1]),
    .c1_valid_o (vo[1]),
    .mem        (mem_if),
    .err_o      (err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      wr[i] = 1'b0;
      ad[i] = 16'h0;
      wd[i] = 16'h0;
    end
    mem_if.ack = 1'b0;
    mem_if.rdata = 16'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic single(input int idx, input tv_t t);
    int v = -1;
    int reqc = 0;
    int other = 0;
    int exp_req;
    logic [15:0] got;
    exp_req = (t.lat >= 1 && t.lat <= T) ? t.lat : T;
    en[t.core] = 1'b1;
    wr[t.core] = t.we;
    ad[t.core] = t.addr;
    wd[t.core] = t.wdata;
    for (int j = 1; j <= 40 && v < 0; j++) begin
      @(negedge clk);
      if (vo[t.core]) v = j;
      if (vo[!t.core]) other++;
      if (mem_if.req) begin
        reqc++;
        if (reqc == 1) begin
          chk($sformatf("tv%0d_we", idx), mem_if.we, t.we);
          chk($sformatf("tv%0d_addr", idx), mem_if.addr, t.addr);
          chk($sformatf("tv%0d_wdata", idx), mem_if.wdata, t.wdata);
        end
      end
      mem_if.ack = (j == t.lat);
      mem_if.rdata = (j == t.lat) ? t.rd : 16'($urandom);
    end
    mem_if.ack = 1'b0;
    got = rdo[t.core];
    chk($sformatf("tv%0d_valid_cycle", idx), v, exp_req + 1);
    chk($sformatf("tv%0d_req_cycles", idx), reqc, exp_req);
    chk($sformatf("tv%0d_other_valid", idx), other, 0);
    chk($sformatf("tv%0d_rdata", idx), got, t.exp_rd);
    chk($sformatf("tv%0d_err", idx), err_o, t.exp_err);
    @(negedge clk);
    en[t.core] = 1'b0;
    got = rdo[t.core];
    chk($sformatf("tv%0d_pulse_width", idx), vo[t.core], 0);
    chk($sformatf("tv%0d_rdata_hold", idx), got, t.exp_rd);
    chk($sformatf("tv%0d_no_regrant", idx), mem_if.req, 0);
    @(negedge clk);
    chk($sformatf("tv%0d_idle_req", idx), mem_if.req, 0);
  endtask
  task automatic seq_alternate();
    int order[$];
    int since = 0;
    logic upd[2];
    logic [15:0] exp;
    do_reset();
    upd[0] = 1'b0;
    upd[1] = 1'b0;
    for (int i = 0; i < 2; i++) en[i] = 1'b1;
    ad[0] = 16'h0100;
    ad[1] = 16'h0200;
    for (int j = 0; j < 60 && order.size() < 4; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (upd[i]) begin
        chk("alt_pulse_width", vo[i], 0);
        ad[i] = ad[i] + 16'h1;
        upd[i] = 1'b0;
      end
      chk("alt_single_valid", vo[0] & vo[1], 0);
      for (int i = 0; i < 2; i++) if (vo[i]) begin
        order.push_back(i);
        exp = ~ad[i];
        chk("alt_rdata", rdo[i], exp);
        upd[i] = 1'b1;
      end
      since = mem_if.req ? since + 1 : 0;
      mem_if.ack = (since == 2);
      mem_if.rdata = ~mem_if.addr;
    end
    chk("alt_grants", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk($sformatf("alt_order%0d", k), order[k], k % 2);
    do_reset();
  endtask
  task automatic seq_reset_busy();
    tv_t t;
    do_reset();
    chk("rb_err_cleared", err_o, 0);
    en[0] = 1'b1;
    ad[0] = 16'h0042;
    @(negedge clk);
    chk("rb_req_up", mem_if.req, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rb_req_async_drop", mem_if.req, 0);
    en[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rb_no_valid", {vo[1], vo[0]}, 0);
    end
    reset_n = 1'b1;
    t = '{1'b1, 1'b0, 16'h0055, 16'h0, 2, 16'hCAFE, 16'hCAFE, 1'b0};
    single(100, t);
    en[0] = 1'b1;
    en[1] = 1'b1;
    ad[0] = 16'h0066;
    ad[1] = 16'h0077;
    @(negedge clk);
    chk("rb_tie_to_core0", mem_if.addr, 16'h0066);
    do_reset();
  endtask
  task automatic rand_test(input int n);
    int e = 0;
    int busy = 0;
    int ge = 0;
    int k = 0;
    int ee = 0;
    int fe = 1;
    int w = 0;
    int last = 1;
    int grants = 0;
    int r;
    logic to = 1'b0;
    logic err_m = 1'b0;
    logic cw;
    logic [15:0] ca, cd, exp_rd, got;
    logic [15:0] marr[256];
    for (int i = 0; i < 256; i++) marr[i] = 16'($urandom);
    do_reset();
    for (int it = 0; it < n; it++) begin
      @(negedge clk);
      e++;
      if (busy != 0 && e == ee && to) err_m = 1'b1;
      chk("rnd_req", mem_if.req, busy != 0 && e >= ge && e < ee);
      if (busy != 0 && e >= ge && e < ee) begin
        chk("rnd_we", mem_if.we, cw);
        chk("rnd_addr", mem_if.addr, ca);
        chk("rnd_wdata", mem_if.wdata, cd);
      end
      for (int i = 0; i < 2; i++) begin
        chk("rnd_valid", vo[i], busy != 0 && e == ee && w == i);
        if (busy != 0 && e == ee && w == i) begin
          got = rdo[i];
          chk("rnd_rdata", got, exp_rd);
        end
      end
      chk("rnd_err", err_o, err_m);
      if (busy != 0 && e == ee + 1) begin
        busy = 0;
        last = w;
        fe = e + 1;
        en[w] = 1'b0;
      end
      for (int i = 0; i < 2; i++) if (!en[i] && $urandom_range(0, 3) == 0) begin
        en[i] = 1'b1;
        wr[i] = 1'($urandom_range(0, 1));
        ad[i] = 16'($urandom);
        wd[i] = 16'($urandom);
      end
      if (busy == 0 && e + 1 >= fe && (en[0] || en[1])) begin
        w = (en[0] && en[1]) ? 1 - last : (en[1] ? 1 : 0);
        busy = 1;
        grants++;
        ge = e + 1;
        r = $urandom_range(0, 9);
        k = r < 6 ? $urandom_range(1, 4) : r == 6 ? T : r == 7 ? 0 : $urandom_range(5, T - 1);
        to = (k == 0);
        ee = to ? ge + T : ge + k;
        cw = wr[w];
        ca = ad[w];
        cd = wd[w];
        exp_rd = to ? 16'hDEAD : (cw ? 16'h0 : marr[ca[7:0]]);
      end
      if (busy != 0 && !to && e + 1 == ge + k) begin
        mem_if.ack = 1'b1;
        mem_if.rdata = cw ? 16'($urandom) : marr[ca[7:0]];
        if (cw) marr[ca[7:0]] = cd;
      end else begin
        mem_if.ack = !(busy != 0 && e + 1 > ge && e + 1 <= ee) && ($urandom_range(0, 7) == 0);
        mem_if.rdata = 16'($urandom);
      end
    end
    chk("rnd_activity", grants > n / 20, 1);
    do_reset();
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      wr[i] = 1'b0;
      ad[i] = 16'h0;
      wd[i] = 16'h0;
    end
    mem_if.ack = 1'b0;
    mem_if.rdata = 16'h0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", mem_if.req, 0);
    chk("rst_we", mem_if.we, 0);
    chk("rst_addr", mem_if.addr, 0);
    chk("rst_wdata", mem_if.wdata, 0);
    chk("rst_valid", {vo[1], vo[0]}, 0);
    chk("rst_rdata0", rdo[0], 0);
    chk("rst_rdata1", rdo[1], 0);
    chk("rst_err", err_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tv[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'h1234, 16'h1234, 1'b0};
    tv[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 1, 16'h5555, 16'h0000, 1'b0};
    tv[2] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 3, 16'h5A5A, 16'h5A5A, 1'b0};
    tv[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, T, 16'h7777, 16'h7777, 1'b0};
    tv[4] = '{1'b0, 1'b1, 16'h0050, 16'h1111, T - 1, 16'h9999, 16'h0000, 1'b0};
    tv[5] = '{1'b1, 1'b0, 16'h0060, 16'h0000, 0, 16'h0000, 16'hDEAD, 1'b1};
    tv[6] = '{1'b0, 1'b0, 16'h0070, 16'h0000, 2, 16'h0101, 16'h0101, 1'b1};
    tv[7] = '{1'b0, 1'b1, 16'h0080, 16'h2222, 0, 16'h0000, 16'hDEAD, 1'b1};
    for (int i = 0; i < 8; i++) single(i, tv[i]);
    seq_alternate();
    seq_reset_busy();
    rand_test(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vcore_dmem_arbiter.md
Name: vcore_dmem_arbiter

Overview:
- Shares one single-port 16-bit data memory between the dmem ports of two vcore instances (core 0, core 1).
- Serialises requests with round-robin arbitration and one outstanding transaction at a time.
- Returns each core's dmem_valid_i pulse and read data.
- Adds a memory-ack timeout so a stuck memory model is flagged instead of hanging both cores.

Parameters:
- DATA_W, 16: data width, core and memory side.
- ADDR_W, 16: address width.
- TIMEOUT, 15: maximum cycles in BUSY waiting for mem_ack_i; valid range 1..255.
- ERR_DATA, 16'hDEAD: read data returned on timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- c0_enable_i  in  1  core 0 dmem_enable_o
- c0_write_i  in  1  core 0 dmem_write_o
- c0_addr_i  in  ADDR_W  core 0 dmem_addr_o
- c0_wdata_i  in  DATA_W  core 0 dmem_data_o
- c0_rdata_o  out  DATA_W  to core 0 dmem_data_i
- c0_valid_o  out  1  to core 0 dmem_valid_i
- c1_* : same six signals for core 1
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  read data, valid while mem_ack_i = 1
- mem_ack_i  in  1  completion, one-cycle pulse
- err_o  out  1  sticky timeout flag

Behaviour:
- Core protocol: a core holds enable, write, addr and wdata stable until it sees valid high for one cycle. It may raise a new request in the cycle after valid.
- Reset (async assert, sync release):
  - state = IDLE; all outputs 0; err_o = 0.
  - last_grant = 1, so core 0 wins the first tie.
  - timeout counter = 0.
- FSM IDLE:
  - If any enable is high, pick the winner, register its write/addr/wdata into mem_* and assert mem_req_o from the next cycle. Go to BUSY.
  - Winner selection: single requester wins; when both request, the winner is the core opposite to last_grant.
  - No request: stay in IDLE.
- FSM BUSY:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held constant.
  - Counter increments each cycle.
  - On mem_ack_i: capture mem_rdata_i, or capture 0 for a write. Clear mem_req_o. Go to RESP.
  - On counter reaching TIMEOUT without ack: capture ERR_DATA, set err_o, clear mem_req_o, go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins and err_o is not set.
- FSM RESP:
  - Pulse c{winner}_valid_o for exactly one cycle, with c{winner}_rdata_o = captured data.
  - Set last_grant = winner, clear the counter, go to IDLE.
  - Requests are not sampled in RESP, so the served core's still-high enable is never re-granted.
- rdata outputs: registered; hold their last value outside the valid cycle. The non-winner's valid stays 0.
- Latency: request seen in IDLE at cycle n; mem_req_o high at n+1. An ack at cycle n+k gives valid at n+k+1. Minimum end-to-end latency is 2 cycles (ack at n+1, valid at n+2). Minimum request-to-request spacing per arbiter is 3 cycles.
- Fairness: with both cores requesting continuously, grants strictly alternate.
- Request withdrawn (enable dropped) after grant: this is a protocol violation; the transaction still completes and valid is still pulsed.
- mem_ack_i outside BUSY: ignored.
- Reset mid-transaction: the FSM aborts immediately, mem_req_o drops asynchronously, and no valid is issued.
- Counter width: clog2(TIMEOUT+1); the counter never wraps.

Decomposition:
- Shared package vcore_pkg:
  - state enum {IDLE, BUSY, RESP}
  - DATA_W and ADDR_W defaults
  - ERR_DATA constant
- One sub-module, vcore_rr_pick: combinational 2-way round-robin picker. Inputs: req[1:0] and last_grant. Outputs: gnt_valid and gnt_idx.
- Everything else (FSM, capture registers, timeout counter) stays in the top.

Test Plan:
- Core 0 read, addr 16'h0010; memory acks 1 cycle after req with 16'h1234 → mem_req_o high 1 cycle after request; c0_valid_o one cycle later with c0_rdata_o = 16'h1234; c1_valid_o stays 0.
- Core 1 write, addr 16'h0020, data 16'hBEEF → mem_we_o = 1, mem_addr_o = 16'h0020, mem_wdata_o = 16'hBEEF; c1_valid_o pulses with c1_rdata_o = 0.
- Both cores request continuously from reset (reads, ack latency 2) → grant order is 0, 1, 0, 1; each valid is a one-cycle pulse; no double grant.
- Memory never acks with TIMEOUT = 15 → mem_req_o drops after 15 BUSY cycles; winner gets valid with rdata = 16'hDEAD; err_o = 1 and stays 1 through later good transactions.
- Ack arrives in the same cycle the counter hits TIMEOUT → normal data returned; err_o stays 0.
- reset_n asserted while in BUSY → mem_req_o = 0 immediately; no valid pulse; after release, a core 1-only request is served normally and the next tie goes to core 0.
